// File: rtl/uart_pkg.sv
//==============================================================================
// Module      : uart_pkg
// Description : Shared UART constants, FSM state encoding and helpers (TX/RX).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_pkg;

    localparam int c_DWIDTH       = 8;
    localparam int c_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
//==============================================================================
// Module      : uart_bit_timer
// Description : Free-running 0..CLKS_PER_BIT-1 bit timer with terminal pulse.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int                 c_CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign bit_end = (r_cnt == c_LAST) && !clear;

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo_drain.sv
//==============================================================================
// Module      : uart_tx_fifo_drain
// Description : UART transmitter draining the TX FIFO; optional even parity
//               bit enabled by defining UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_fifo_drain
    import uart_pkg::*;
#(
    parameter int DWIDTH       = c_DWIDTH,
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_rdata,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int                 c_IDX_W    = cnt_width(DWIDTH);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DWIDTH - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DWIDTH-1:0]   r_shift;
    logic [DWIDTH-1:0]   w_shift_nxt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_IDX_W-1:0]  w_idx_nxt;
    logic                r_tx;
    logic                w_tx_nxt;
    logic                r_tx_done;
    logic                w_tx_done_nxt;
    logic                w_idle;
    logic                w_pop;
    logic                w_bit_end;
`ifdef UART_TX_PARITY_EN
    logic                r_parity;
`endif

    assign w_idle = (r_state == ST_IDLE);
    // Gating with reset keeps a pending byte in the FIFO while reset is held.
    assign w_pop  = w_idle & ~fifo_empty & ~reset;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_idle),
        .bit_end (w_bit_end)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_idx_nxt     = r_idx;
        w_tx_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = ST_START;
                    w_shift_nxt = fifo_rdata;
                    w_idx_nxt   = '0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_idx == c_IDX_LAST) begin
                        w_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end else begin
                        w_idx_nxt = r_idx + c_IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt   = ST_IDLE;
                    w_tx_done_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // tx is registered from the upcoming state so the line only changes at an edge.
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx_nxt = r_parity;
`endif
            default:   w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_tx      <= 1'b1;
            r_tx_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_tx      <= w_tx_nxt;
            r_tx_done <= w_tx_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
`ifdef UART_TX_PARITY_EN
        if (w_pop) begin
            r_parity <= ^fifo_rdata;
        end
`endif
    end

    assign fifo_rd = w_pop;
    assign busy    = w_pop | (~reset & ~w_idle);
    assign tx      = r_tx;
    assign tx_done = r_tx_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo_drain.sv
//==============================================================================
// Module      : tb_uart_tx_fifo_drain
// Description : Scoreboard bench for uart_tx_fifo_drain (CLKS_PER_BIT=4, 8 bits).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_tx_fifo_drain;

    localparam int C    = 4;
    localparam int DW   = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = DW + 3;
`else
    localparam int FRAME = DW + 2;
`endif
    localparam int SPAN = FRAME * C;
    localparam int HIST = 20000;

    typedef struct {
        logic [DW-1:0] data;
        int            pop;
    } exp_t;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_rd;
    logic          tx;
    logic          busy;
    logic          tx_done;

    logic [DW-1:0] fifo_q[$];
    exp_t          exp_q[$];
    int            pop_log[$];
    logic [DW-1:0] pop_dat[$];
    logic          tx_hist[HIST];
    int            cyc   = 0;
    int            n_chk = 0;
    int            n_bad = 0;

    uart_tx_fifo_drain #(
        .DWIDTH       (DW),
        .CLKS_PER_BIT (C)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_chk++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic [DW-1:0] b);
        @(posedge clk);
        #1;
        fifo_q.push_back(b);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(n < budget, "idle_timeout", n, budget);
    endtask

    // FIFO model: pops on fifo_rd and records the expected frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (fifo_rd) begin
                chk(fifo_empty == 1'b0, "rd_while_empty", fifo_empty, 0);
                chk(reset == 1'b0, "rd_during_reset", reset, 0);
                if (fifo_q.size() != 0) begin
                    e.data = fifo_rdata;
                    e.pop  = cyc;
                    exp_q.push_back(e);
                    pop_log.push_back(cyc);
                    pop_dat.push_back(fifo_rdata);
                    void'(fifo_q.pop_front());
                end
            end
            @(posedge clk);
            #2;
            fifo_empty = (fifo_q.size() == 0);
            fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        end
    end

    // Monitor: line/status checks every cycle, frame decode at each tx_done.
    initial begin
        exp_t          e;
        logic          prev_rst;
        logic          exp_busy;
        logic          active;
        logic [DW-1:0] rx_data;
        logic          rx_bit;
        logic          rx_start;
        logic          rx_stop;
        logic          rx_par;
        int            base;
        int            unstable;
        prev_rst = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (cyc < HIST) tx_hist[cyc] = tx;
            exp_busy = 1'b0;
            active   = 1'b0;
            foreach (exp_q[i]) begin
                if (cyc >= exp_q[i].pop && cyc <= exp_q[i].pop + SPAN) exp_busy = 1'b1;
                if (cyc >= exp_q[i].pop + 1 && cyc <= exp_q[i].pop + SPAN) active = 1'b1;
            end
            chk(busy === exp_busy, "busy", busy, exp_busy);
            if (!active && !(reset && !prev_rst)) chk(tx === 1'b1, "tx_idle_high", tx, 1);
            if (tx_done) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_bad++;
                    $display("FAIL unexpected_tx_done: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk(cyc == e.pop + SPAN + 1, "tx_done_cycle", cyc, e.pop + SPAN + 1);
                    unstable = 0;
                    rx_data  = '0;
                    rx_start = 1'b1;
                    rx_stop  = 1'b0;
                    rx_par   = 1'b0;
                    for (int b = 0; b < FRAME; b++) begin
                        base   = e.pop + 1 + b * C;
                        rx_bit = tx_hist[base];
                        for (int k = 1; k < C; k++)
                            if (tx_hist[base + k] !== rx_bit) unstable++;
                        if (b == 0) rx_start = rx_bit;
                        else if (b <= DW) rx_data[b-1] = rx_bit;
                        else if (b == FRAME - 1) rx_stop = rx_bit;
                        else rx_par = rx_bit;
                    end
                    chk(tx_hist[e.pop] === 1'b1, "idle_in_pop_cycle", tx_hist[e.pop], 1);
                    chk(unstable == 0, "bit_stable", unstable, 0);
                    chk(rx_start === 1'b0, "start_bit", rx_start, 0);
                    chk(rx_data === e.data, "data_bits", rx_data, e.data);
                    chk(rx_stop === 1'b1, "stop_bit", rx_stop, 1);
`ifdef UART_TX_PARITY_EN
                    chk(rx_par === ^e.data, "parity_bit", rx_par, ^e.data);
`endif
                end
            end
            if (exp_q.size() != 0 && cyc > exp_q[0].pop + SPAN + 1) begin
                n_chk++;
                n_bad++;
                $display("FAIL tx_done_missing: got 0 expected 1 (cycle %0d)", exp_q[0].pop + SPAN + 1);
                void'(exp_q.pop_front());
            end
            prev_rst = reset;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int np;
        int n;
        int t;
        fifo_q.push_back(8'h5A);
        fifo_empty = 1'b0;
        fifo_rdata = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk(fifo_rd === 1'b1, "first_pop_after_reset", fifo_rd, 1);
        wait_idle(200);

        np = pop_log.size();
        push(8'hA5);
        wait_idle(200);
        chk(pop_log.size() == np + 1, "a5_pop_count", pop_log.size() - np, 1);

        np = pop_log.size();
        push(8'h00);
        push(8'hFF);
        wait_idle(300);
        chk(pop_log.size() == np + 2, "b2b_pop_count", pop_log.size() - np, 2);
        if (pop_log.size() == np + 2)
            chk(pop_log[np+1] - pop_log[np] == SPAN + 1, "b2b_spacing", pop_log[np+1] - pop_log[np], SPAN + 1);

        np = pop_log.size();
        repeat (200) @(posedge clk);
        #1;
        chk(pop_log.size() == np, "empty_no_pop", pop_log.size() - np, 0);

        np = pop_log.size();
        push(8'h3C);
        n = 0;
        while (pop_log.size() == np && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(n < 100, "pop_3c_wait", n, 100);
        if (pop_log.size() > np) begin
            t = pop_log[np] + 1 + 4 * C + 1;
            n = 0;
            while (cyc < t && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            reset = 1'b1;
            exp_q.delete();
            fifo_q.push_back(8'h96);
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b0;
            chk(pop_log.size() == np + 1, "no_pop_in_reset", pop_log.size() - np, 1);
            wait_idle(200);
            chk(pop_log.size() == np + 2, "pop_after_reset", pop_log.size() - np, 2);
            if (pop_dat.size() == np + 2)
                chk(pop_dat[np+1] == 8'h96, "next_byte_after_reset", pop_dat[np+1], 8'h96);
        end

        push(8'h07);
        push(8'h03);
        wait_idle(300);

        for (int i = 0; i < 24; i++) begin
            push(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) push(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2 * SPAN)) @(posedge clk);
        end
        wait_idle(4000);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
